// File: rtl/fp13_to_int_seq_if.sv
// Operand/result bundle for fp13_to_int_seq: 13-bit float in, OUT_W-bit signed integer out.
// Handshake: a transfer occurs on a rising clk edge where valid and ready are both high;
// the valid side holds its payload stable until that edge, and ready never depends on valid.
interface fp13_to_int_seq_if #(parameter int OUT_W = 16);
  logic             in_valid;
  logic             in_ready;
  logic             sign_in;
  logic [3:0]       exp_in;
  logic [7:0]       frac_in;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] int_out;
  logic             out_zero;
  logic             out_inexact;

  modport master (
    output in_valid, sign_in, exp_in, frac_in, out_ready,
    input  in_ready, out_valid, int_out, out_zero, out_inexact
  );

  modport slave (
    input  in_valid, sign_in, exp_in, frac_in, out_ready,
    output in_ready, out_valid, int_out, out_zero, out_inexact
  );
endinterface

// File: rtl/fp13_to_int_seq.sv
// Bit-serial fp13 (sign, 4-bit exp, 8-bit frac, no hidden bit) to signed integer converter.
// Optional macro ROUND_NEAREST_EN: round half away from zero instead of truncating.
module fp13_to_int_seq #(
  parameter int OUT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  fp13_to_int_seq_if.slave    bus,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SIGN  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [23:0]      mag;
  logic [3:0]       cnt;
  logic             sign_q;
  logic [OUT_W-1:0] int_q;
  logic             zero_q;
  logic             inexact_q;
  logic             accept;
  logic [15:0]      m;
  logic [OUT_W-1:0] m_ext;
  logic [OUT_W-1:0] m_signed;

  assign accept = bus.in_valid && (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (bus.in_valid) state_nx = (bus.exp_in != 4'd0) ? SHIFT : SIGN;
      SHIFT: if (cnt == 4'd1) state_nx = SIGN;
      SIGN:  state_nx = DONE;
      DONE:  if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // mag[23:8] is the integer part, mag[7:0] the fraction; max 0xFF<<15 cannot overflow 16 bits
`ifdef ROUND_NEAREST_EN
  assign m = mag[23:8] + {15'd0, mag[7]};
`else
  assign m = mag[23:8];
`endif

  assign m_ext    = OUT_W'(m);
  assign m_signed = sign_q ? -m_ext : m_ext;  // -0 == 0, so a zero magnitude is always +0

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag       <= '0;
      cnt       <= '0;
      sign_q    <= 1'b0;
      int_q     <= '0;
      zero_q    <= 1'b0;
      inexact_q <= 1'b0;
    end else if (accept) begin
      mag    <= {16'd0, bus.frac_in};
      cnt    <= bus.exp_in;
      sign_q <= bus.sign_in;
    end else if (state == SHIFT) begin
      mag <= mag << 1;
      cnt <= cnt - 4'd1;
    end else if (state == SIGN) begin
      int_q     <= m_signed;
      zero_q    <= (m == 16'd0);
      inexact_q <= |mag[7:0];
    end
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.int_out     = int_q;
  assign bus.out_zero    = zero_q;
  assign bus.out_inexact = inexact_q;
  assign dbg_state       = state;

endmodule

// File: tb/tb_fp13_to_int_seq.sv
// Directed self-checking bench for fp13_to_int_seq with hand-computed expected results.
module tb_fp13_to_int_seq;
  localparam int OUT_W = 16;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [OUT_W-1:0] exp_q[$];

`ifdef ROUND_NEAREST_EN
  localparam logic [15:0] C0_INT  = 16'h0001;
  localparam logic        C0_ZERO = 1'b0;
  localparam logic [15:0] B8_INT  = 16'h000C;
`else
  localparam logic [15:0] C0_INT  = 16'h0000;
  localparam logic        C0_ZERO = 1'b1;
  localparam logic [15:0] B8_INT  = 16'h000B;
`endif

  fp13_to_int_seq_if #(.OUT_W(OUT_W)) bus ();

  fp13_to_int_seq #(.OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the accept edge.
  task automatic send(input logic s, input logic [3:0] e, input logic [7:0] f, input string tag);
    int w;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    check({tag, "_ready_wait"}, 32'(w < 40), 32'd1);
    bus.sign_in  = s;
    bus.exp_in   = e;
    bus.frac_in  = f;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) begin
        lat = c;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic check_out(input string tag, input logic ez, input logic ex);
    logic [OUT_W-1:0] ei;
    ei = '0;
    check({tag, "_q_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) ei = exp_q.pop_front();
    check({tag, "_int"},     32'(bus.int_out), 32'(ei));
    check({tag, "_zero"},    32'(bus.out_zero), 32'(ez));
    check({tag, "_inexact"}, 32'(bus.out_inexact), 32'(ex));
    check({tag, "_in_ready_busy"}, 32'(bus.in_ready), 32'd0);
  endtask

  task automatic release_out(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic do_op(input logic s, input logic [3:0] e, input logic [7:0] f,
                       input logic [OUT_W-1:0] ei, input logic ez, input logic ex,
                       input string tag);
    exp_q.push_back(ei);
    send(s, e, f, tag);
    wait_valid(tag, int'(e) + 1);
    check_out(tag, ez, ex);
    release_out(tag);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.sign_in   = 1'b0;
    bus.exp_in    = 4'd0;
    bus.frac_in   = 8'd0;
    bus.out_ready = 1'b0;
    #3;
    check("rst_in_ready",  32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_int_out",   32'(bus.int_out), 32'd0);
    check("rst_zero",      32'(bus.out_zero), 32'd0);
    check("rst_inexact",   32'(bus.out_inexact), 32'd0);
    check("rst_state",     32'(dbg_state), 32'd0);
    #19 rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(1'b0, 4'd1,  8'h80, 16'h0001, 1'b0,    1'b0, "one");
    do_op(1'b1, 4'd15, 8'hFF, 16'h8080, 1'b0,    1'b0, "max_neg");
    do_op(1'b0, 4'd0,  8'hC0, C0_INT,   C0_ZERO, 1'b1, "exp0_frac");
    do_op(1'b1, 4'd3,  8'hA0, 16'hFFFB, 1'b0,    1'b0, "neg5");
    do_op(1'b1, 4'd7,  8'h00, 16'h0000, 1'b1,    1'b0, "neg_zero");

    // Backpressure with a second operand waiting the whole time
    exp_q.push_back(B8_INT);
    send(1'b0, 4'd4, 8'hB8, "bp_a");
    bus.sign_in  = 1'b1;
    bus.exp_in   = 4'd1;
    bus.frac_in  = 8'h80;
    bus.in_valid = 1'b1;
    wait_valid("bp_a", 5);
    check_out("bp_a", 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_valid",    32'(bus.out_valid), 32'd1);
      check("bp_hold_int",      32'(bus.int_out), 32'(B8_INT));
      check("bp_hold_inexact",  32'(bus.out_inexact), 32'd1);
      check("bp_hold_zero",     32'(bus.out_zero), 32'd0);
      check("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    release_out("bp_a");
    exp_q.push_back(16'hFFFF);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp_b_accepted", 32'(bus.in_ready), 32'd0);
    wait_valid("bp_b", 2);
    check_out("bp_b", 1'b0, 1'b0);
    release_out("bp_b");

    // Asynchronous reset in the middle of a long shift
    send(1'b0, 4'd12, 8'hFF, "abort");
    repeat (4) @(posedge clk);
    #1;
    check("abort_in_shift", 32'(dbg_state), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_in_ready",  32'(bus.in_ready), 32'd1);
    check("abort_state",     32'(dbg_state), 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(1'b0, 4'd2, 8'h90, 16'h0002, 1'b0, 1'b1, "fresh");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fp13_to_int_seq.md
Name: fp13_to_int_seq

Overview:
- Sequential converter from the team's 13-bit floating-point format to a signed two's-complement integer. Format is sign, 4-bit exponent, 8-bit fraction. Value = (-1)^sign × (frac/256) × 2^exp, with no hidden bit.
- Sits downstream of the floating-point adder and decodes its result (sign_out/exp_out/frac_out) into an integer for display or a datapath.
- Shifts the magnitude by one bit per cycle under a small FSM, with valid/ready handshakes on both sides.

Parameters:
- OUT_W, 16, output integer width; legal range 16..32. Result is sign-extended to OUT_W. 16 is enough because the maximum magnitude is 32640.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input operand valid
- in_ready  output  1  converter can accept an operand
- sign_in  input  1  operand sign
- exp_in  input  4  operand exponent, unsigned
- frac_in  input  8  operand fraction; MSB is normally 1, unnormalized values are still accepted
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- int_out  output  OUT_W  signed integer result
- out_zero  output  1  int_out == 0
- out_inexact  output  1  nonzero fraction bits were discarded

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; in_ready=1; out_valid=0; int_out=0; out_zero=0; out_inexact=0.
  - Internal 24-bit magnitude register and 4-bit counter cleared.
  - Reset mid-operation aborts the conversion with no output.
- Datapath: mag[23:0]; mag[23:8] is the integer part, mag[7:0] the fraction part.
- States: IDLE, SHIFT, SIGN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at edge T0: mag={16'b0,frac_in}; cnt=exp_in; sign captured.
  - Next state is SHIFT if exp_in≠0, else SIGN.
  - Inputs are sampled only at the accept edge.
- SHIFT:
  - Each edge: mag=mag<<1; cnt=cnt-1.
  - When cnt==1 at the edge, next state is SIGN.
  - Occupies exactly exp cycles.
- SIGN (one cycle):
  - Magnitude m = mag[23:8], truncated toward zero.
  - int_out = sign ? -m : m, sign-extended to OUT_W.
  - out_zero = (m==0).
  - out_inexact = |mag[7:0].
  - out_valid=1; next state DONE.
  - A zero magnitude always gives +0; the sign bit is ignored.
- Latency: out_valid rises at edge T0+exp+1, i.e. 1..16 cycles after accept.
- DONE:
  - int_out and flags are held stable while out_valid=1.
  - On out_valid&out_ready: out_valid=0 and state=IDLE.
  - in_ready returns the next cycle. There is no input/output overlap, so throughput is one conversion per exp+3 cycles at best.
- in_ready=0 in SHIFT, SIGN and DONE. in_valid is ignored there.
- A new operand must not be accepted on the same edge as the output handshake.
- Arithmetic:
  - No overflow is possible; 255×2^15/256 = 32640 < 2^15.
  - Negation is two's complement over OUT_W bits.

Optional Feature:
- ROUND_NEAREST_EN:
  - Defined: in SIGN, m = mag[23:8] + mag[7], i.e. round half away from zero on the magnitude. out_inexact is unchanged (still |mag[7:0] before rounding). out_zero reflects the rounded m. m still fits, since the max is 32640.
  - Undefined: truncation as above, and the rounding adder is not synthesized.

Test Plan:
- sign=0, exp=1, frac=0x80, out_ready=1 → int_out=1, out_valid at T0+2, inexact=0, zero=0.
- sign=1, exp=15, frac=0xFF → int_out=16'h8080 (-32640) at T0+16, inexact=0. With OUT_W=24 → 24'hFF8080.
- sign=0, exp=0, frac=0xC0 → int_out=0, zero=1, inexact=1, out_valid at T0+1. With ROUND_NEAREST_EN → int_out=1, zero=0, inexact=1.
- sign=1, exp=3, frac=0xA0 → int_out=16'hFFFB (-5), inexact=0. sign=1, frac=0x00, exp=7 → int_out=0, zero=1 (no negative zero).
- Back-to-back: hold out_ready=0 for 5 cycles after out_valid → int_out and flags stable and in_ready=0 throughout. Raise out_ready → out_valid drops, and in_ready=1 the following cycle. A second in_valid held during busy is accepted only then.
- Assert rst_n=0 asynchronously during SHIFT of exp=12 → out_valid=0 and in_ready=1 immediately. After release, a fresh exp=2, frac=0x90 operand → int_out=2, inexact=1, no stale result.
